// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and counter sizing for the bit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_1bit.sv
// adder_1bit: full-adder cell used as the serial datapath
module adder_1bit (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_piso_shreg.sv
// piso_shreg: parallel-load, shift-right register with LSB serial output
module piso_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         so
);

    logic [W-1:0] q;

    // load wins over shift; zeros fill in from the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= d;
        else if (shift)
            q <= {1'b0, q[W-1:1]};
    end

    assign so = q[0];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: N-bit adder processing one bit pair per clock, LSB first
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CW = cnt_width(N);

    state_t        state, state_nxt;
    logic          load, run, last;
    logic          a_bit, b_bit, carry, s_bit, c_bit;
    logic [CW-1:0] cnt;
    logic [N-2:0]  shs;
    logic [N-1:0]  res;

    assign load = (state == IDLE) && start;
    assign run  = (state == RUN);
    assign last = run && (cnt == CW'(N - 1));
    assign res  = {s_bit, shs};

    piso_shreg #(.W(N)) u_sha (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (run),
        .d     (a),
        .so    (a_bit)
    );

    piso_shreg #(.W(N)) u_shb (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (run),
        .d     (b),
        .so    (b_bit)
    );

    adder_1bit u_add (
        .A    (a_bit),
        .B    (b_bit),
        .Cin  (carry),
        .Sum  (s_bit),
        .Cout (c_bit)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next state: start only matters in IDLE, DONE always falls back to IDLE
    always_comb begin
        state_nxt = (state == IDLE) ? (start ? RUN : IDLE) :
                    (state == RUN)  ? (last ? DONE : RUN) : IDLE;
    end

    // handshake outputs decoded from state
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // carry, bit counter, partial result and published result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry <= 1'b0;
            cnt   <= '0;
            shs   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            if (load) begin
                carry <= cin;
                cnt   <= '0;
            end else if (run) begin
                carry <= c_bit;
                cnt   <= cnt + 1'b1;
                shs   <= res[N-1:1];
            end
            if (last) begin
                sum  <= res;
                cout <= c_bit;
            end
        end
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the existing adder_1bit cell. It feeds that cell one operand bit pair per clock, LSB first, and feeds the cell's carry back through a carry flip-flop.
- It consumes the Sum/Cout stream of adder_1bit and assembles the full N-bit result.
- It sits between the operand source, a start/done handshake, and downstream logic that reads sum/cout.

Parameters:
- N, 8, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  N  operand A; captured on the accepted start edge.
- b  input  N  operand B; captured on the accepted start edge.
- cin  input  1  initial carry-in; captured on the accepted start edge.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle pulse marking that sum/cout have just been updated.
- sum  output  N  registered N-bit result.
- cout  output  1  registered final carry-out.

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is asynchronous and active-high.
- On rst assertion, regardless of state and immediately (not clock-gated):
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry flip-flop and bit counter are cleared.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - IDLE with start=1 at edge t: load shA<=a, shB<=b, carry<=cin, cnt<=0; next state RUN.
  - IDLE with start=0: stay in IDLE.
- RUN, each edge:
  - The adder_1bit instance sees A=shA[0], B=shB[0], Cin=carry.
  - Result shift register shS <= {Sum, shS[N-1:1]} (fill at MSB, shift right).
  - shA, shB shift right with 0 fill; carry<=Cout; cnt<=cnt+1.
- RUN exit: at the edge where cnt==N-1, the final bit is processed and the state moves to DONE. On that same edge:
  - sum <= {Sum, shS[N-1:1]}
  - cout <= Cout
- DONE: done=1 for exactly this one cycle; next edge returns to IDLE unconditionally.
- Timing relative to the start edge t:
  - Bits are processed on edges t+1..t+N.
  - busy=1 for exactly N cycles (RUN state).
  - done=1 in the cycle following edge t+N.
  - Minimum start-to-start spacing is N+2 edges.
- Ignored starts: start is ignored in RUN and DONE. It is not queued and does not alter the captured operands.
- Output stability: sum and cout change only on the edge entering DONE, or on reset. They hold between operations and are never partial during RUN.
- busy and done are never high together.
- Arithmetic: modulo 2^N sum with carry-out, i.e. {cout,sum} = a + b + cin, (N+1)-bit exact.
- Counter width: clog2(N); it must not wrap before cnt==N-1 is detected.
- Reset mid-RUN: the in-flight operation is abandoned; no done pulse is issued and sum/cout go to 0. A start in the first cycle after reset release is accepted normally.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Counter-width function/constant derived from N.
- Sub-modules:
  - Reuse adder_1bit unchanged as the arithmetic datapath; no new gate-level adder.
  - One new sub-module is natural: piso_shreg (parallel-load, shift-right, async active-high clear), instantiated twice for shA and shB.
- The FSM, counter, carry flip-flop and result register stay in serial_adder.

Test Plan:
- Reset with random inputs toggling -> busy=0, done=0, sum=0x00, cout=0. Async check: change on rst rising, no clock edge required.
- N=8, a=0x3C, b=0x05, cin=0, start at edge t -> busy high for cycles t+1..t+8; done single pulse after edge t+8; sum=0x41, cout=0; values held afterwards.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple through the flip-flop).
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then start held high continuously from IDLE -> back-to-back operations exactly N+2 edges apart, each with one done pulse.
- Start a=0x01, b=0x01, cin=0, then re-assert start with a=0xAA, b=0x55 during RUN and during DONE -> both ignored; result sum=0x02, cout=0.
- Start a=0x0F, b=0x01, assert rst after 3 RUN edges -> outputs immediately 0, no done pulse. After release, start a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1.
